alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational `alu` instance (4-bit op, 32-bit a/b, 32-bit out) between NUM_REQ requesters.
- Typical requesters: the execute stage and the address-generation unit.
- Round-robin arbitration, valid/ready handshakes on both sides, and one registered result stage.
- Sits between issue logic and writeback/AGU consumers. The result is tagged with the requester ID.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ID_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), width of rsp_id.
- STAT_W, 16, width of each statistics counter (used only with ALU_ARB_STATS_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_op  in  NUM_REQ*4  packed ALU ops, requester i at [4i+3:4i].
- req_a  in  NUM_REQ*32  packed operand A.
- req_b  in  NUM_REQ*32  packed operand B.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that produced rsp_data.
- rsp_data  out  32  registered ALU result.

Behaviour:
- **Reset** (async, rst_n=0): rsp_valid=0, rsp_data=0, rsp_id=0, round-robin pointer=0 (requester 0 highest priority). req_ready=0 while in reset.
- **Accept condition:** `can_accept = !rsp_valid || rsp_ready`.
- **Grant:** first i with req_valid[i]=1, searching from the pointer upward and wrapping modulo NUM_REQ. req_ready[i]=1 only for that i, and only when can_accept. req_ready is combinational from req_valid; requesters must not derive valid from ready.
- **Transfer:** occurs when req_valid[i] && req_ready[i]. Granted op/a/b are muxed into the alu. At the next edge: rsp_data<=alu out, rsp_id<=i, rsp_valid<=1, pointer<=(i+1) mod NUM_REQ.
- **Latency and throughput:** exactly 1 cycle from accept to rsp_valid. With rsp_ready held high, throughput is 1 result/cycle.
- **Backpressure:** while rsp_valid && !rsp_ready, rsp_data and rsp_id hold stable and all req_ready=0.
- **Drain without refill:** rsp_valid && rsp_ready with no request granted → rsp_valid<=0 next edge.
- **Simultaneous drain and accept:** the register is overwritten with the new result; rsp_valid stays 1.
- **No valid requests:** no grant, pointer holds.
- **Pointer update:** the pointer advances only on an accepted transfer, never on idle cycles.
- **NUM_REQ=1:** pointer is constant 0; rsp_id=0.
- **Reset mid-operation:** in-flight result discarded; requesters must reissue.
- **Arithmetic:** entirely the alu's. 32-bit wrap-around, no flags.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined: adds output ports stat_grants (NUM_REQ*STAT_W, per-requester accepted-transfer count) and stat_stall (STAT_W).
  - stat_stall counts cycles with any req_valid=1 but no transfer.
  - Counters saturate at all-ones; reset to 0 asynchronously.
  - stat_clr (in, 1) synchronously clears all counters; clear wins over a same-cycle increment.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t (4-bit enum). ALU_ADD=4'h0, ALU_SUB=4'h8 plus the remaining alu encodings.
  - ALU_W=32.
  - ALU_OP_W=4.
- Sub-module rr_arbiter (parameter N): inputs req, advance; outputs one-hot grant and grant index; owns the round-robin pointer register.
- alu_arbiter instantiates rr_arbiter and alu, and owns the result register and stats.

Test Plan:
- Only req0: req_op=ALU_ADD, a=32'h5, b=32'h7, rsp_ready=1 → req_ready=2'b01 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=32'hC.
- After reset, both req_valid held 1, rsp_ready=1 → grants 0,1,0,1,… on consecutive cycles; rsp_id alternates with 1-cycle lag.
- Backpressure: result 32'hC pending, rsp_ready=0 for 3 cycles → req_ready=0, rsp_data stays 32'hC. Raise rsp_ready with req1 valid → req1 accepted that cycle; next rsp_id=1.
- req1: req_op=ALU_SUB, a=0, b=1 → rsp_data=32'hFFFFFFFF.
- Assert rst_n=0 mid-cycle while rsp_valid=1 → rsp_valid=0 immediately, before the next edge. After release, first grant goes to requester 0 even if requester 1 was next.
- With ALU_ARB_STATS_EN and STAT_W=2: 5 accepted transfers from req1 → stat_grants[1]=2'b11 (saturated). Pulse stat_clr → 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode encodings and datapath widths
package alu_pkg;

    localparam int ALU_W    = 32;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SLL  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SRL  = 4'h5,
        ALU_OR   = 4'h6,
        ALU_AND  = 4'h7,
        ALU_SUB  = 4'h8,
        ALU_SRA  = 4'hD
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU, wrap-around arithmetic, no flags; unknown ops yield 0
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [ALU_W-1:0]    a_i,
    input  logic [ALU_W-1:0]    b_i,
    output logic [ALU_W-1:0]    y_o
);

    // Opcode decode; shift amounts use the low five bits of b
    always_comb begin
        y_o = '0;
        case (alu_op_t'(op_i))
            ALU_ADD:  y_o = a_i + b_i;
            ALU_SUB:  y_o = a_i - b_i;
            ALU_SLL:  y_o = a_i << b_i[4:0];
            ALU_SRL:  y_o = a_i >> b_i[4:0];
            ALU_SRA:  y_o = $signed(a_i) >>> b_i[4:0];
            ALU_SLT:  y_o = {{(ALU_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: y_o = {{(ALU_W-1){1'b0}}, a_i < b_i};
            ALU_XOR:  y_o = a_i ^ b_i;
            ALU_OR:   y_o = a_i | b_i;
            ALU_AND:  y_o = a_i & b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; pointer marks the highest-priority requester
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d, idx;
    logic [IW:0]   sum;

    // Search from the pointer upward with wrap; walking downward lets the nearest hit win
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        sum         = '0;
        idx         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            idx = IW'(sum >= (IW+1)'(N) ? sum - (IW+1)'(N) : sum);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
        ptr_d = !advance_i ? ptr_q : (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
    end

    // Pointer moves past the winner only on an accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU with a registered, ID-tagged result; ALU_ARB_STATS_EN adds grant/stall counters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int STAT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
    input  logic [NUM_REQ*ALU_W-1:0]    req_a,
    input  logic [NUM_REQ*ALU_W-1:0]    req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
`ifdef ALU_ARB_STATS_EN
    input  logic                        stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]   stat_grants,
    output logic [STAT_W-1:0]           stat_stall,
`endif
    output logic [ALU_W-1:0]            rsp_data
);

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gidx, id_q, id_d;
    logic [ALU_OP_W-1:0] op;
    logic [ALU_W-1:0]    a, b, alu_y, data_q, data_d;
    logic                valid_q, valid_d, xfer;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_valid),
        .advance_i   (xfer),
        .grant_o     (grant),
        .grant_idx_o (gidx)
    );

    alu u_alu (
        .op_i (op),
        .a_i  (a),
        .b_i  (b),
        .y_o  (alu_y)
    );

    // Grant is exposed only when the result slot is free or draining, and never during reset
    always_comb begin
        req_ready = (rst_n && (!valid_q || rsp_ready)) ? grant : '0;
        xfer      = |req_ready;
        op        = '0;
        a         = '0;
        b         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op = req_op[i*ALU_OP_W +: ALU_OP_W];
                a  = req_a[i*ALU_W +: ALU_W];
                b  = req_b[i*ALU_W +: ALU_W];
            end
        end
        valid_d = xfer ? 1'b1 : rsp_ready ? 1'b0 : valid_q;
        data_d  = xfer ? alu_y : data_q;
        id_d    = xfer ? gidx : id_q;
    end

    // Result register; reset discards any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] grants_q, grants_d;
    logic [STAT_W-1:0]              stall_q, stall_d;

    // Saturating counters; clear beats a same-cycle increment
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            grants_d[i] = stat_clr ? '0 : (req_ready[i] && grants_q[i] != '1) ? grants_q[i] + STAT_W'(1) : grants_q[i];
        stall_d = stat_clr ? '0 : (|req_valid && !xfer && stall_q != '1) ? stall_q + STAT_W'(1) : stall_q;
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q <= '0;
            stall_q  <= '0;
        end else begin
            grants_q <= grants_d;
            stall_q  <= stall_d;
        end
    end

    assign stat_grants = grants_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;

    localparam int N = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*4-1:0]   req_op = '0;
    logic [N*32-1:0]  req_a = '0;
    logic [N*32-1:0]  req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [0:0]       rsp_id;
    logic [31:0]      rsp_data;
`ifdef ALU_ARB_STATS_EN
    logic             stat_clr = 1'b0;
    logic [N*16-1:0]  stat_grants;
    logic [15:0]      stat_stall;
`endif

    int tests = 0;
    int fails = 0;

    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    logic [0:0]  m_id;
    int          m_grants[N];
    int          m_stall;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
`ifdef ALU_ARB_STATS_EN
        .stat_clr    (stat_clr),
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall),
`endif
        .rsp_data    (rsp_data)
    );

    function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] x, logic [31:0] y);
        case (op)
            4'h0: return x + y;
            4'h8: return x - y;
            4'h1: return x << y[4:0];
            4'h5: return x >> y[4:0];
            4'hD: return $signed(x) >>> y[4:0];
            4'h2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'h3: return (x < y) ? 32'd1 : 32'd0;
            4'h4: return x ^ y;
            4'h6: return x | y;
            4'h7: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_grant();
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = '0; m_id = '0; m_stall = 0;
        for (int i = 0; i < N; i++) m_grants[i] = 0;
    endtask

    task automatic set_req(int i, bit v, logic [3:0] op, logic [31:0] x, logic [31:0] y);
        req_valid[i] = v;
        req_op[i*4 +: 4] = op;
        req_a[i*32 +: 32] = x;
        req_b[i*32 +: 32] = y;
    endtask

    task automatic tick();
        int g;
        g = exp_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_data = alu_ref(req_op[g*4 +: 4], req_a[g*32 +: 32], req_b[g*32 +: 32]);
            m_id = 1'(g);
            m_valid = 1;
            m_ptr = (g + 1) % N;
        end else if (rsp_ready) m_valid = 0;
`ifdef ALU_ARB_STATS_EN
        if (stat_clr) begin
            m_stall = 0;
            for (int i = 0; i < N; i++) m_grants[i] = 0;
        end else if (g >= 0) m_grants[g]++;
        else if (|req_valid) m_stall++;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid = '1;
        rsp_ready = 1;
        @(negedge clk);
        #1;
        tests += 4;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
        if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", rsp_data); end
        if (rsp_id !== 1'b0) begin fails++; $display("FAIL reset_id got %b want 0", rsp_id); end
        if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", req_ready); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_single();
        set_req(0, 1, 4'h0, 32'h5, 32'h7);
        req_valid[1] = 0;
        rsp_ready = 1;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready got %b want 01", req_ready); end
        tick();
        tests += 3;
        if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        if (rsp_id !== 1'b0) begin fails++; $display("FAIL single_id got %b want 0", rsp_id); end
        if (rsp_data !== 32'hC) begin fails++; $display("FAIL single_data got %h want c", rsp_data); end
        req_valid = '0;
        tick();
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_sub();
        set_req(1, 1, 4'h8, 32'h0, 32'h1);
        #1;
        tests++;
        if (req_ready !== 2'b10) begin fails++; $display("FAIL sub_ready got %b want 10", req_ready); end
        tick();
        tests += 2;
        if (rsp_data !== 32'hFFFFFFFF) begin fails++; $display("FAIL sub_data got %h want ffffffff", rsp_data); end
        if (rsp_id !== 1'b1) begin fails++; $display("FAIL sub_id got %b want 1", rsp_id); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        set_req(0, 1, 4'h0, 32'd1, 32'd2);
        set_req(1, 1, 4'h8, 32'd10, 32'd3);
        rsp_ready = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            tests++;
            if (req_ready !== ((c % 2) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL rr_ready cycle %0d got %b", c, req_ready); end
            tick();
            tests += 2;
            if (rsp_id !== 1'(c % 2)) begin fails++; $display("FAIL rr_id cycle %0d got %b want %0d", c, rsp_id, c % 2); end
            if (rsp_data !== ((c % 2) ? 32'd7 : 32'd3)) begin fails++; $display("FAIL rr_data cycle %0d got %h", c, rsp_data); end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        set_req(0, 1, 4'h0, 32'h5, 32'h7);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests += 3;
            if (req_ready !== 2'b00) begin fails++; $display("FAIL bp_ready cycle %0d got %b want 00", c, req_ready); end
            if (rsp_data !== 32'hC) begin fails++; $display("FAIL bp_data cycle %0d got %h want c", c, rsp_data); end
            if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cycle %0d got %b want 1", c, rsp_valid); end
            tick();
        end
        rsp_ready = 1;
        req_valid[0] = 0;
        set_req(1, 1, 4'h8, 32'h0, 32'h1);
        #1;
        tests++;
        if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_release_ready got %b want 10", req_ready); end
        tick();
        tests += 3;
        if (rsp_id !== 1'b1) begin fails++; $display("FAIL bp_release_id got %b want 1", rsp_id); end
        if (rsp_data !== 32'hFFFFFFFF) begin fails++; $display("FAIL bp_release_data got %h", rsp_data); end
        if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_release_valid got %b want 1", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        set_req(0, 1, 4'h0, 32'h1, 32'h1);
        req_valid[1] = 0;
        rsp_ready = 1;
        tick();
        #2;
        rst_n = 0;
        #1;
        tests += 2;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b want 0", rsp_valid); end
        if (req_ready !== 2'b00) begin fails++; $display("FAIL midreset_ready got %b want 00", req_ready); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL midreset_grant got %b want 01", req_ready); end
        tick();
        tests++;
        if (rsp_id !== 1'b0) begin fails++; $display("FAIL midreset_id got %b want 0", rsp_id); end
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_op[i*4 +: 4] = 4'($urandom);
                req_a[i*32 +: 32] = $urandom;
                req_b[i*32 +: 32] = ($urandom % 3 == 0) ? $urandom % 40 : $urandom;
            end
            rsp_ready = ($urandom % 4) != 0;
            #1;
            g = exp_grant();
            tests++;
            if (req_ready !== ((g < 0) ? 2'b00 : 2'(1 << g))) begin fails++; $display("FAIL rand_ready cycle %0d got %b grant %0d", c, req_ready, g); end
            tick();
            tests += 3;
            if (rsp_valid !== m_valid) begin fails++; $display("FAIL rand_valid cycle %0d got %b want %b", c, rsp_valid, m_valid); end
            if (rsp_data !== m_data) begin fails++; $display("FAIL rand_data cycle %0d got %h want %h", c, rsp_data, m_data); end
            if (rsp_id !== m_id) begin fails++; $display("FAIL rand_id cycle %0d got %b want %b", c, rsp_id, m_id); end
        end
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < N; i++) begin
            tests++;
            if (stat_grants[i*16 +: 16] !== 16'(m_grants[i])) begin fails++; $display("FAIL stat_grants%0d got %0d want %0d", i, stat_grants[i*16 +: 16], m_grants[i]); end
        end
        tests++;
        if (stat_stall !== 16'(m_stall)) begin fails++; $display("FAIL stat_stall got %0d want %0d", stat_stall, m_stall); end
        stat_clr = 1;
        req_valid = 2'b11;
        rsp_ready = 1;
        tick();
        stat_clr = 0;
        tests += 2;
        if (stat_grants !== '0) begin fails++; $display("FAIL stat_clr_grants got %h want 0", stat_grants); end
        if (stat_stall !== '0) begin fails++; $display("FAIL stat_clr_stall got %0d want 0", stat_stall); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_sub();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
